// File: rtl/change_dispenser.sv
// Greedy coin-return sequencer: pays out a cent amount as quarters,
// dimes and nickels, one registered eject pulse at a time.
module change_dispenser #(
   parameter int WIDTH        = 10,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic             inClk,
   input  logic             inReset,
   input  logic             inStart,
   input  logic [WIDTH-1:0] inAmount,
   input  logic             inQuarterEmpty,
   input  logic             inDimeEmpty,
   input  logic             inNickelEmpty,
   output logic             outReady,
   output logic             outQuarter,
   output logic             outDime,
   output logic             outNickel,
   output logic [WIDTH-1:0] outRemaining,
   output logic             outDone,
   output logic             outError
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_PULSE  = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [WIDTH-1:0] V25 = WIDTH'(25);
   localparam logic [WIDTH-1:0] V10 = WIDTH'(10);
   localparam logic [WIDTH-1:0] V5  = WIDTH'(5);

   localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [2:0]       coin_q, coin_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [WIDTH-1:0] amt_mod5;

   assign amt_mod5 = inAmount % V5;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      coin_d  = coin_q;
      unique case (state_q)
         S_IDLE: begin
            if (inStart) begin
               rem_d = inAmount;
               err_d = 1'b0;
               if (amt_mod5 != '0) begin
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  state_d = S_SELECT;
               end
            end
         end
         S_SELECT: begin
            // Priority order gives greedy largest-coin-first selection.
            if (rem_q == '0) begin
               state_d = S_FINISH;
            end else if (rem_q >= V25 && !inQuarterEmpty) begin
               coin_d  = 3'b100;
               rem_d   = rem_q - V25;
               cnt_d   = P_LOAD;
               state_d = S_PULSE;
            end else if (rem_q >= V10 && !inDimeEmpty) begin
               coin_d  = 3'b010;
               rem_d   = rem_q - V10;
               cnt_d   = P_LOAD;
               state_d = S_PULSE;
            end else if (rem_q >= V5 && !inNickelEmpty) begin
               coin_d  = 3'b001;
               rem_d   = rem_q - V5;
               cnt_d   = P_LOAD;
               state_d = S_PULSE;
            end else begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               coin_d  = 3'b000;
               cnt_d   = G_LOAD;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_SELECT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FINISH: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            coin_d  = 3'b000;
         end
      endcase
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_FINISH);
      error_d = done_d & err_d;
   end

   always_ff @(posedge inClk or posedge inReset) begin
      if (inReset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         coin_q  <= 3'b000;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         coin_q  <= coin_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign outReady     = ready_q;
   assign outQuarter   = coin_q[2];
   assign outDime      = coin_q[1];
   assign outNickel    = coin_q[0];
   assign outRemaining = rem_q;
   assign outDone      = done_q;
   assign outError     = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: cycle-by-cycle trace checks
// against hand-derived coin sequences.
module tb_change_dispenser;

   logic       inClk = 1'b0;
   logic       inReset;
   logic       inStart;
   logic [9:0] inAmount;
   logic       inQuarterEmpty;
   logic       inDimeEmpty;
   logic       inNickelEmpty;
   logic       outReady;
   logic       outQuarter;
   logic       outDime;
   logic       outNickel;
   logic [9:0] outRemaining;
   logic       outDone;
   logic       outError;

   int checks = 0;
   int errors = 0;

   change_dispenser #(.WIDTH(10), .PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
      .inClk          (inClk),
      .inReset        (inReset),
      .inStart        (inStart),
      .inAmount       (inAmount),
      .inQuarterEmpty (inQuarterEmpty),
      .inDimeEmpty    (inDimeEmpty),
      .inNickelEmpty  (inNickelEmpty),
      .outReady       (outReady),
      .outQuarter     (outQuarter),
      .outDime        (outDime),
      .outNickel      (outNickel),
      .outRemaining   (outRemaining),
      .outDone        (outDone),
      .outError       (outError)
   );

   always #5 inClk = ~inClk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // coins: 2 bits per coin, first coin in [1:0]; 1=quarter 2=dime 3=nickel
   task automatic run(input logic [9:0] amt, input logic qe, input logic de,
                      input logic ne, input int nc, input logic [7:0] coins,
                      input logic exp_err, input int poke);
      int         dc;
      int         rem;
      logic [2:0] ej;
      logic [1:0] cd;
      inQuarterEmpty = qe;
      inDimeEmpty    = de;
      inNickelEmpty  = ne;
      inAmount       = amt;
      inStart        = 1'b1;
      @(posedge inClk);
      @(negedge inClk);
      inStart = 1'b0;
      dc = (amt % 5 != 0) ? 1 : 2 + 7 * nc;
      for (int c = 1; c <= dc + 1; c++) begin
         rem = amt;
         ej  = 3'b000;
         for (int k = 0; k < nc; k++) begin
            cd = coins[2*k +: 2];
            if (c >= 2 + 7 * k) begin
               rem = rem - ((cd == 2'd1) ? 25 : (cd == 2'd2) ? 10 : 5);
               if (c <= 5 + 7 * k)
                  ej = (cd == 2'd1) ? 3'b100 : (cd == 2'd2) ? 3'b010 : 3'b001;
            end
         end
         chk("remaining", outRemaining, rem);
         chk("eject", {outQuarter, outDime, outNickel}, ej);
         chk("done", outDone, c == dc);
         chk("error", outError, (c == dc) && exp_err);
         chk("ready", outReady, c > dc);
         if (c == poke) begin
            inStart  = 1'b1;
            inAmount = 10'd100;
         end else if (c == poke + 1) begin
            inStart = 1'b0;
         end
         @(negedge inClk);
      end
      inStart = 1'b0;
   endtask

   initial begin
      inReset        = 1'b1;
      inStart        = 1'b0;
      inAmount       = '0;
      inQuarterEmpty = 1'b0;
      inDimeEmpty    = 1'b0;
      inNickelEmpty  = 1'b0;
      @(negedge inClk);
      @(negedge inClk);
      chk("rst_ready", outReady, 1);
      chk("rst_eject", {outQuarter, outDime, outNickel}, 0);
      chk("rst_rem", outRemaining, 0);
      chk("rst_done", outDone, 0);
      chk("rst_err", outError, 0);
      inReset = 1'b0;
      @(negedge inClk);

      // 40: Q, D, N
      run(10'd40, 0, 0, 0, 3, 8'b00_11_10_01, 0, 0);
      // 30 with quarters empty: D, D, D
      run(10'd30, 1, 0, 0, 3, 8'b00_10_10_10, 0, 0);
      // 15 with nickels empty: D then stuck at 5
      run(10'd15, 0, 0, 1, 1, 8'b00_00_00_10, 1, 0);
      chk("err_rem_hold", outRemaining, 5);
      // not a multiple of 5
      run(10'd7, 0, 0, 0, 0, 8'b0, 1, 0);
      chk("odd_rem_hold", outRemaining, 7);
      // zero amount
      run(10'd0, 0, 0, 0, 0, 8'b0, 0, 0);
      // start during busy ignored
      run(10'd25, 0, 0, 0, 1, 8'b00_00_00_01, 0, 3);
      // 70: Q, Q, D, D
      run(10'd70, 0, 0, 0, 4, 8'b10_10_01_01, 0, 0);

      // reset during 2nd cycle of quarter pulse
      inAmount = 10'd25;
      inStart  = 1'b1;
      @(posedge inClk);
      @(negedge inClk);
      inStart = 1'b0;
      @(negedge inClk);
      @(negedge inClk);
      chk("pre_rst_q", outQuarter, 1);
      #2 inReset = 1'b1;
      #1;
      chk("midrst_q", outQuarter, 0);
      chk("midrst_rem", outRemaining, 0);
      chk("midrst_ready", outReady, 1);
      chk("midrst_done", outDone, 0);
      @(negedge inClk);
      inReset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge inClk);
         chk("postrst_done", outDone, 0);
         chk("postrst_ready", outReady, 1);
      end
      run(10'd40, 0, 0, 0, 3, 8'b00_11_10_01, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
